// File: rtl/and_gate.sv
// Bitwise AND: c/all_high combinational, c_q/c_rise one register stage, no backpressure.
// Define AND_GATE_STATS_EN to build the saturating hi_count statistics counter.
module and_gate #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clr,
   output logic [WIDTH-1:0] c,
   output logic             all_high,
   output logic [WIDTH-1:0] c_q,
   output logic [WIDTH-1:0] c_rise,
   output logic [CNT_W-1:0] hi_count
);

   assign c        = a & b;
   assign all_high = &c;

   // c_rise compares against the previous c_q, so it pulses the same cycle c_q first goes high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q    <= '0;
         c_rise <= '0;
      end else begin
         c_q    <= c;
         c_rise <= c & ~c_q;
      end
   end

`ifdef AND_GATE_STATS_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (all_high && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign hi_count = cnt_q;
`else
   logic unused_clr;

   assign unused_clr = clr;
   assign hi_count   = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Randomized bench for and_gate against a per-cycle behavioural model (stats-aware via AND_GATE_STATS_EN).
module tb_and_gate;

   localparam int W    = 4;
   localparam int CW   = 3;
   localparam int MAXC = (1 << CW) - 1;
`ifdef AND_GATE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          clr = 1'b0;
   logic [W-1:0]  c;
   logic          all_high;
   logic [W-1:0]  c_q;
   logic [W-1:0]  c_rise;
   logic [CW-1:0] hi_count;

   int vectors = 0;
   int errors  = 0;

   // Behavioural model state: what the registered outputs should show now
   logic [W-1:0] m_cq   = '0;
   logic [W-1:0] m_rise = '0;
   int           m_cnt  = 0;

   and_gate #(.WIDTH(W), .CNT_W(CW)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .clr      (clr),
      .c        (c),
      .all_high (all_high),
      .c_q      (c_q),
      .c_rise   (c_rise),
      .hi_count (hi_count)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] and_ref(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = (x[i] == 1'b1 && y[i] == 1'b1);
      return r;
   endfunction

   function automatic logic [CW-1:0] exp_cnt();
      return STATS ? CW'(m_cnt) : '0;
   endfunction

   // One rising edge: advance the model from the inputs present at the edge, then settle
   task automatic tick();
      logic [W-1:0] cur;
      @(posedge clk);
      cur = and_ref(a, b);
      if (rst) begin
         m_cq = '0; m_rise = '0; m_cnt = 0;
      end else begin
         for (int i = 0; i < W; i++) m_rise[i] = cur[i] && !m_cq[i];
         m_cq = cur;
         if (clr) m_cnt = 0;
         else if (cur == {W{1'b1}} && m_cnt < MAXC) m_cnt = m_cnt + 1;
      end
      #1;
   endtask

   task automatic test_reset();
      logic [W-1:0] e;
      for (int k = 0; k < 12; k++) begin
         a = W'($urandom); b = W'($urandom);
         if (k % 3 == 0) b = '1;
         #1;
         e = and_ref(a, b);
         vectors++;
         if (c !== e) begin errors++; $display("FAIL reset_comb_c: got %h want %h", c, e); end
         vectors++;
         if (all_high !== (e == {W{1'b1}})) begin errors++; $display("FAIL reset_all_high: got %b want %b", all_high, (e == {W{1'b1}})); end
         vectors++;
         if (c_q !== '0 || c_rise !== '0 || hi_count !== '0) begin
            errors++; $display("FAIL reset_regs: c_q=%h c_rise=%h hi_count=%0d want all 0", c_q, c_rise, hi_count);
         end
         #3;
      end
      a = '1; b = '1;
      tick();
      vectors++;
      if (c_q !== '0 || hi_count !== '0) begin errors++; $display("FAIL reset_hold_edge: c_q=%h hi_count=%0d want 0", c_q, hi_count); end
      a = '0; b = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_hold_high();
      a = '1; b = '1; clr = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         vectors++;
         if (c_q !== '1) begin errors++; $display("FAIL hold_cq_%0d: got %h want %h", k, c_q, {W{1'b1}}); end
         vectors++;
         if (c_rise !== (k == 1 ? {W{1'b1}} : {W{1'b0}})) begin
            errors++; $display("FAIL hold_rise_%0d: got %h want %h", k, c_rise, (k == 1 ? {W{1'b1}} : {W{1'b0}}));
         end
         vectors++;
         if (hi_count !== (STATS ? CW'(k) : '0)) begin
            errors++; $display("FAIL hold_count_%0d: got %0d want %0d", k, hi_count, (STATS ? k : 0));
         end
      end
   endtask

   task automatic test_clr();
      a = '1; b = '1; clr = 1'b1;
      tick();
      vectors++;
      if (hi_count !== '0) begin errors++; $display("FAIL clr_zero: got %0d want 0", hi_count); end
      clr = 1'b0;
      tick();
      vectors++;
      if (hi_count !== exp_cnt()) begin errors++; $display("FAIL clr_resume: got %0d want %0d", hi_count, exp_cnt()); end
      vectors++;
      if (c_q !== m_cq) begin errors++; $display("FAIL clr_cq_kept: got %h want %h", c_q, m_cq); end
   endtask

   task automatic test_saturate();
      a = '1; b = '1; clr = 1'b0;
      for (int k = 0; k < MAXC + 3; k++) begin
         tick();
         vectors++;
         if (hi_count !== exp_cnt()) begin errors++; $display("FAIL sat_count_%0d: got %0d want %0d", k, hi_count, exp_cnt()); end
      end
      vectors++;
      if (hi_count !== (STATS ? CW'(MAXC) : '0)) begin errors++; $display("FAIL sat_final: got %0d want %0d", hi_count, (STATS ? MAXC : 0)); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         a = W'($urandom); b = W'($urandom);
         if ($urandom_range(0, 3) == 0) begin a = '1; b = '1; end
         clr = ($urandom_range(0, 9) == 0);
         tick();
         vectors++;
         if (c_q !== m_cq) begin errors++; $display("FAIL rand_cq_%0d: got %h want %h", k, c_q, m_cq); end
         vectors++;
         if (c_rise !== m_rise) begin errors++; $display("FAIL rand_rise_%0d: got %h want %h", k, c_rise, m_rise); end
         vectors++;
         if (hi_count !== exp_cnt()) begin errors++; $display("FAIL rand_count_%0d: got %0d want %0d", k, hi_count, exp_cnt()); end
      end
      clr = 1'b0;
   endtask

   task automatic test_async_reset();
      a = '1; b = '1;
      tick();
      tick();
      #2;
      rst = 1'b1;
      m_cq = '0; m_rise = '0; m_cnt = 0;
      #1;
      vectors++;
      if (c_q !== '0 || c_rise !== '0 || hi_count !== '0) begin
         errors++; $display("FAIL async_rst: c_q=%h c_rise=%h hi_count=%0d want all 0", c_q, c_rise, hi_count);
      end
      vectors++;
      if (c !== '1 || all_high !== 1'b1) begin errors++; $display("FAIL async_rst_comb: c=%h all_high=%b want %h 1", c, all_high, {W{1'b1}}); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      vectors++;
      if (c_q !== '1 || c_rise !== '1) begin errors++; $display("FAIL rst_release_pulse: c_q=%h c_rise=%h want %h %h", c_q, c_rise, {W{1'b1}}, {W{1'b1}}); end
      vectors++;
      if (hi_count !== exp_cnt()) begin errors++; $display("FAIL rst_release_count: got %0d want %0d", hi_count, exp_cnt()); end
   endtask

   initial begin
      test_reset();
      test_hold_high();
      test_clr();
      test_saturate();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
